// File: rtl/rifl_pkg.sv
// rifl_pkg: shared payload field offsets, arbiter FSM state type and round-robin pick helper
package rifl_pkg;
  localparam int PAYLOAD_WIDTH_DEF = 240;
  localparam int CH_ID_W_DEF = 2;
  localparam int VLD_BIT = PAYLOAD_WIDTH_DEF + 1;
  localparam int LAST_BIT = PAYLOAD_WIDTH_DEF;
  localparam int CHID_LSB = PAYLOAD_WIDTH_DEF - CH_ID_W_DEF;
  typedef enum logic {ARB, LOCK} arb_state_e;
  // First set bit at or after ptr, modulo n; returns ptr when nothing is set.
  function automatic logic [3:0] rr_pick(input logic [15:0] vld, input logic [3:0] ptr, input int n);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int i = n - 1; i >= 0; i--) begin
      idx = 4'((int'(ptr) + i) % n);
      if (vld[idx]) rr_pick = idx;
    end
  endfunction
endpackage

// File: rtl/rifl_rr_picker.sv
// rifl_rr_picker: combinational round-robin pick of the next valid channel starting at ptr_i
module rifl_rr_picker
  import rifl_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int CH_ID_W = 2
) (
  input  logic [N_CH-1:0]    vld_i,
  input  logic [CH_ID_W-1:0] ptr_i,
  output logic [CH_ID_W-1:0] idx_o
);
  assign idx_o = CH_ID_W'(rr_pick(16'(vld_i), 4'(ptr_i), N_CH));
endmodule

// File: rtl/rifl_tx_arbiter.sv
// rifl_tx_arbiter: round-robin, burst-locked mux of N_CH streams onto the RIFL TX payload.
// RIFL_TX_ARB_PRIO_EN makes channel 0 strict priority at each arbitration decision.
module rifl_tx_arbiter
  import rifl_pkg::*;
#(
  parameter int PAYLOAD_WIDTH = PAYLOAD_WIDTH_DEF,
  parameter int N_CH = 4,
  parameter int CH_ID_W = CH_ID_W_DEF,
  parameter int MAX_BURST = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [N_CH*(PAYLOAD_WIDTH-CH_ID_W)-1:0]  s_tdata,
  input  logic [N_CH-1:0]                          s_tvalid,
  input  logic [N_CH-1:0]                          s_tlast,
  output logic [N_CH-1:0]                          s_tready,
  input  logic                                     rifl_tx_ready,
  output logic [PAYLOAD_WIDTH+1:0]                 rifl_tx_payload,
  output logic [CH_ID_W-1:0]                       grant_ch,
  output logic                                     locked
);
  localparam int DATA_W = PAYLOAD_WIDTH - CH_ID_W;
  localparam int BW = $clog2(MAX_BURST);
  logic [PAYLOAD_WIDTH+1:0] out_q, out_d;
  arb_state_e state_q, state_d;
  logic [CH_ID_W-1:0] rr_ptr_q, rr_ptr_d, lock_ch_q, lock_ch_d, pick, grant, nxt;
  logic [BW-1:0] burst_q, burst_d;
  logic [N_CH-1:0] pick_vld;
  logic load, xfer, brk;
`ifdef RIFL_TX_ARB_PRIO_EN
  // Pointer only rotates over channels 1..N_CH-1; a channel-0 grant leaves it alone.
  assign pick_vld = s_tvalid & ~N_CH'(1);
  assign grant = locked ? lock_ch_q : (s_tvalid[0] ? '0 : pick);
  assign nxt = (grant == '0) ? rr_ptr_q :
               (grant == CH_ID_W'(N_CH - 1)) ? CH_ID_W'(1) : grant + CH_ID_W'(1);
`else
  assign pick_vld = s_tvalid;
  assign grant = locked ? lock_ch_q : pick;
  assign nxt = (grant == CH_ID_W'(N_CH - 1)) ? '0 : grant + CH_ID_W'(1);
`endif
  rifl_rr_picker #(.N_CH(N_CH), .CH_ID_W(CH_ID_W)) u_picker (
    .vld_i(pick_vld),
    .ptr_i(rr_ptr_q),
    .idx_o(pick)
  );
  assign locked = state_q == LOCK;
  assign grant_ch = grant;
  assign load = ~out_q[PAYLOAD_WIDTH+1] | rifl_tx_ready;
  assign xfer = load & s_tvalid[grant];
  assign brk = s_tlast[grant] | (locked & (burst_q == BW'(MAX_BURST - 1)));
  assign s_tready = xfer ? N_CH'(1) << grant : '0;
  assign rifl_tx_payload = out_q;
  always_comb begin
    out_d = load ? (xfer ? {1'b1, s_tlast[grant], grant, s_tdata[int'(grant)*DATA_W +: DATA_W]} : '0) : out_q;
    state_d = xfer ? (brk ? ARB : LOCK) : state_q;
    lock_ch_d = (xfer & ~locked) ? grant : lock_ch_q;
    burst_d = xfer ? (brk ? '0 : burst_q + BW'(1)) : burst_q;
    rr_ptr_d = (xfer & brk) ? nxt : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      state_q <= ARB;
      lock_ch_q <= '0;
      burst_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      out_q <= out_d;
      state_q <= state_d;
      lock_ch_q <= lock_ch_d;
      burst_q <= burst_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
